// File: rtl/clock_divider_multi.sv
// N-channel clock divider: per-channel programmable divisor, one-cycle tick enable and 50% square wave.
// Optional macro CLKDIV_SYNC_EN adds a sync input that phase-aligns every channel.
module clock_divider_multi #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 32,
    parameter int DEFAULT_DIV = 100000000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              main_clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] slow_clk
`ifdef CLKDIV_SYNC_EN
    ,
    input  logic              sync
`endif
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    logic r_wr_ack;
    logic r_wr_err;
    logic w_ch_ok;

    // Channel index may exceed NUM_CH when NUM_CH is not a power of two.
    assign w_ch_ok = ({{(32-CH_W){1'b0}}, wr_ch} < 32'(NUM_CH));

    // Write handshake: acknowledge every strobe, flag out-of-range channels.
    always_ff @(posedge main_clk) begin
        if (rst) begin
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_ack <= wr_en;
            r_wr_err <= wr_en & ~w_ch_ok;
        end
    end

    assign wr_ack = r_wr_ack;
    assign wr_err = r_wr_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_div_act;
        logic [DIV_W-1:0] r_div_shd;
        logic [DIV_W-1:0] w_last;
        logic             r_tick;
        logic             r_slow;
        logic             w_wr_hit;
        logic             w_wrap;

        // Terminal count of the running period; a divisor of 0 behaves as 1.
        always_comb begin
            w_last = {DIV_W{1'b0}};
            if (r_div_act != {DIV_W{1'b0}}) begin
                w_last = r_div_act - DIV_W'(1);
            end else begin
                w_last = {DIV_W{1'b0}};
            end
        end

        assign w_wrap   = (r_cnt == w_last);
        assign w_wr_hit = wr_en & (wr_ch == CH_W'(g));

        // Shadow divisor: written any cycle, only adopted by the counter at a wrap.
        always_ff @(posedge main_clk) begin
            if (rst) begin
                r_div_shd <= DEF_DIV;
            end else if (w_wr_hit) begin
                r_div_shd <= wr_div;
            end else begin
                r_div_shd <= r_div_shd;
            end
        end

        // Period counter, tick pulse and square wave; the active divisor changes only at wrap.
        always_ff @(posedge main_clk) begin
            if (rst) begin
                r_cnt     <= {DIV_W{1'b0}};
                r_div_act <= DEF_DIV;
                r_tick    <= 1'b0;
                r_slow    <= 1'b0;
            end
`ifdef CLKDIV_SYNC_EN
            else if (sync) begin
                r_cnt     <= {DIV_W{1'b0}};
                r_div_act <= r_div_shd;
                r_tick    <= 1'b0;
                r_slow    <= 1'b0;
            end
`endif
            else if (w_wrap) begin
                r_cnt     <= {DIV_W{1'b0}};
                r_div_act <= r_div_shd;
                r_tick    <= 1'b1;
                r_slow    <= ~r_slow;
            end else begin
                r_cnt     <= r_cnt + DIV_W'(1);
                r_div_act <= r_div_act;
                r_tick    <= 1'b0;
                r_slow    <= r_slow;
            end
        end

        assign tick[g]     = r_tick;
        assign slow_clk[g] = r_slow;
    end

endmodule
